conv_relu_maxpool: RTL and testbench

- Downstream stage of the 2D convolution accelerator: consumes the signed conv output pixel stream (row-major, Rout x Cout per frame).
- Applies optional ReLU, then 2x2 stride-2 max pooling; emits the pooled pixels row-major over AXI-Stream with a last-beat flag.
- Uses a half-row line buffer, so the convolution block never has to re-send data.

---
 rtl/conv_relu_maxpool.sv | 114 +++++++++++
 tb/tb_conv_relu_maxpool.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_relu_maxpool.sv
// Post-convolution stage: optional ReLU, then 2x2 stride-2 max pooling over a row-major
// pixel stream. One half-row line buffer holds the even-row pair maxima until the odd row arrives.
module conv_relu_maxpool #(
  parameter int W       = 40,
  parameter int MAXR    = 8,
  parameter int MAXC    = 8,
  parameter int RELU_EN = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(MAXR+1)-1:0] CFG_ROWS,
  input  logic [$clog2(MAXC+1)-1:0] CFG_COLS,
  input  logic [W-1:0]              INPUT_TDATA,
  input  logic                      INPUT_TVALID,
  output logic                      INPUT_TREADY,
  output logic [W-1:0]              OUTPUT_TDATA,
  output logic                      OUTPUT_TVALID,
  output logic                      OUTPUT_TLAST,
  input  logic                      OUTPUT_TREADY
);

  localparam int RW  = $clog2(MAXR+1);
  localparam int CW  = $clog2(MAXC+1);
  localparam int LBD = MAXC/2;
  localparam int LBW = (LBD > 1) ? $clog2(LBD) : 1;

  typedef enum logic [1:0] {EVEN_ROW, ODD_ROW, DROP_ROW} state_t;

  state_t              state;
  logic [RW-1:0]       row, rows_l, rows_eff;
  logic [CW-1:0]       col, cols_l, cols_eff;
  logic                active;
  logic signed [W-1:0] x, v, pair_reg, lb_rd, even_max, pool_max;
  logic signed [W-1:0] linebuf [LBD];
  logic [LBW-1:0]      lb_idx;
  logic                accept, col_odd, row_end, frame_end, last_pix, next_drop;

  always_comb begin
    INPUT_TREADY = !OUTPUT_TVALID || OUTPUT_TREADY;
    accept       = INPUT_TVALID && INPUT_TREADY;
    // The first beat of a frame uses the live config; a zero count behaves as one.
    rows_eff = active ? rows_l : ((CFG_ROWS == '0) ? RW'(1) : CFG_ROWS);
    cols_eff = active ? cols_l : ((CFG_COLS == '0) ? CW'(1) : CFG_COLS);
    x        = INPUT_TDATA;
    v        = (RELU_EN != 0 && x < 0) ? '0 : x;
    col_odd  = col[0];
    row_end  = (col == cols_eff - CW'(1));
    frame_end = row_end && (row == rows_eff - RW'(1));
    next_drop = ({1'b0, row} + (RW+1)'(2)) == {1'b0, rows_eff};
    lb_idx   = LBW'(col >> 1);
    lb_rd    = linebuf[lb_idx];
    even_max = (v > pair_reg) ? v : pair_reg;
    pool_max = (lb_rd > even_max) ? lb_rd : even_max;
    last_pix = ((row >> 1) == ((rows_eff >> 1) - RW'(1))) &&
               ((col >> 1) == ((cols_eff >> 1) - CW'(1)));
  end

  // Line buffer has no reset; its contents are rewritten by every even row before use.
  always_ff @(posedge clk) begin
    if (accept && state == EVEN_ROW && col_odd)
      linebuf[lb_idx] <= even_max;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= EVEN_ROW;
      row           <= '0;
      col           <= '0;
      rows_l        <= '0;
      cols_l        <= '0;
      active        <= 1'b0;
      pair_reg      <= '0;
      OUTPUT_TDATA  <= '0;
      OUTPUT_TVALID <= 1'b0;
      OUTPUT_TLAST  <= 1'b0;
    end else begin
      if (OUTPUT_TVALID && OUTPUT_TREADY)
        OUTPUT_TVALID <= 1'b0;
      if (accept) begin
        if (!active) begin
          rows_l <= rows_eff;
          cols_l <= cols_eff;
        end
        if (!col_odd)
          pair_reg <= v;
        if (state == ODD_ROW && col_odd) begin
          OUTPUT_TDATA  <= pool_max;
          OUTPUT_TVALID <= 1'b1;
          OUTPUT_TLAST  <= last_pix;
        end
        if (frame_end) begin
          row    <= '0;
          col    <= '0;
          active <= 1'b0;
          state  <= EVEN_ROW;
        end else begin
          active <= 1'b1;
          if (row_end) begin
            col <= '0;
            row <= row + RW'(1);
            unique case (state)
              EVEN_ROW: state <= ODD_ROW;
              ODD_ROW:  state <= next_drop ? DROP_ROW : EVEN_ROW;
              default:  state <= DROP_ROW;
            endcase
          end else begin
            col <= col + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_relu_maxpool.sv
// Directed bench for conv_relu_maxpool: ramps, ReLU on/off, odd frames, output stall,
// mid-frame reset and degenerate frames, each with hand-computed pooled results.
module tb_conv_relu_maxpool;
  localparam int W    = 40;
  localparam int MAXR = 8;
  localparam int MAXC = 8;
  localparam int RW   = $clog2(MAXR+1);
  localparam int CW   = $clog2(MAXC+1);

  logic clk = 1'b0;
  logic reset;
  logic [RW-1:0] CFG_ROWS;
  logic [CW-1:0] CFG_COLS;
  logic [W-1:0]  INPUT_TDATA;
  logic          INPUT_TVALID, INPUT_TREADY, ready_nr;
  logic [W-1:0]  OUTPUT_TDATA, data_nr;
  logic          OUTPUT_TVALID, OUTPUT_TLAST, OUTPUT_TREADY, valid_nr, last_nr;

  int checks = 0;
  int errors = 0;
  logic signed [W-1:0] stim[$], got_d[$], got_nr[$], exp_d[$];
  logic got_l[$], exp_l[$];
  bit ready_drop = 0;
  bit diverge = 0;
  bit seen;

  always #5 clk = ~clk;

  conv_relu_maxpool #(.W(W), .MAXR(MAXR), .MAXC(MAXC), .RELU_EN(1)) dut (
    .clk(clk), .reset(reset), .CFG_ROWS(CFG_ROWS), .CFG_COLS(CFG_COLS),
    .INPUT_TDATA(INPUT_TDATA), .INPUT_TVALID(INPUT_TVALID), .INPUT_TREADY(INPUT_TREADY),
    .OUTPUT_TDATA(OUTPUT_TDATA), .OUTPUT_TVALID(OUTPUT_TVALID), .OUTPUT_TLAST(OUTPUT_TLAST),
    .OUTPUT_TREADY(OUTPUT_TREADY));

  conv_relu_maxpool #(.W(W), .MAXR(MAXR), .MAXC(MAXC), .RELU_EN(0)) dut_nr (
    .clk(clk), .reset(reset), .CFG_ROWS(CFG_ROWS), .CFG_COLS(CFG_COLS),
    .INPUT_TDATA(INPUT_TDATA), .INPUT_TVALID(INPUT_TVALID), .INPUT_TREADY(ready_nr),
    .OUTPUT_TDATA(data_nr), .OUTPUT_TVALID(valid_nr), .OUTPUT_TLAST(last_nr),
    .OUTPUT_TREADY(OUTPUT_TREADY));

  // Output beats are recorded on the falling edge, ahead of the transferring rising edge.
  always @(negedge clk) begin
    if (OUTPUT_TVALID && OUTPUT_TREADY) begin
      got_d.push_back(OUTPUT_TDATA);
      got_l.push_back(OUTPUT_TLAST);
    end
    if (valid_nr && OUTPUT_TREADY) got_nr.push_back(data_nr);
    if (INPUT_TVALID && !INPUT_TREADY) ready_drop = 1;
    if (!reset && (valid_nr !== OUTPUT_TVALID || last_nr !== OUTPUT_TLAST || ready_nr !== INPUT_TREADY))
      diverge = 1;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic signed [W-1:0] d);
    bit ok;
    ok = 0;
    INPUT_TDATA  = d;
    INPUT_TVALID = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = INPUT_TREADY;
      @(posedge clk);
    end
    chk("beat_accepted", 64'(ok), 64'(1));
    #1;
  endtask

  // Config is scrambled after the first beat so only the latched values can be in use.
  task automatic send_frame(input int r, input int c);
    CFG_ROWS = RW'(r);
    CFG_COLS = CW'(c);
    for (int i = 0; i < stim.size(); i++) begin
      send_beat(stim[i]);
      if (i == 0) begin
        CFG_ROWS = RW'(3);
        CFG_COLS = CW'(7);
      end
    end
    stim.delete();
  endtask

  task automatic idle(input int n);
    INPUT_TVALID = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) stim.push_back(W'(i));
  endtask

  task automatic push_exp(input int d, input bit l);
    exp_d.push_back(W'(d));
    exp_l.push_back(l);
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk({tag, "_data"}, 64'(got_d[i]), 64'(exp_d[i]));
      chk({tag, "_last"}, 64'(got_l[i]), 64'(exp_l[i]));
    end
    got_d.delete(); got_l.delete(); got_nr.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  initial begin
    reset = 1'b1; INPUT_TVALID = 1'b0; INPUT_TDATA = '0; OUTPUT_TREADY = 1'b1;
    CFG_ROWS = RW'(4); CFG_COLS = CW'(4);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(OUTPUT_TVALID), '0);
    chk("rst_tlast",  64'(OUTPUT_TLAST), '0);
    chk("rst_tdata",  64'($signed(OUTPUT_TDATA)), '0);
    chk("rst_tready", 64'(INPUT_TREADY), 64'(1));
    reset = 1'b0;
    @(posedge clk); #1;

    // 4x4 ramp with ReLU
    ramp(16);
    ready_drop = 0;
    send_frame(4, 4);
    idle(5);
    chk("t1_in_ready_high", 64'(ready_drop), '0);
    push_exp(5, 0); push_exp(7, 0); push_exp(13, 0); push_exp(15, 1);
    check_out("t1");

    // Negative frame: bypass instance keeps sign, ReLU instance clamps
    for (int i = 0; i < 16; i++) stim.push_back((i == 11) ? W'(-1) : W'(-3));
    send_frame(4, 4);
    idle(5);
    chk("t2_nr_count", 64'(got_nr.size()), 64'(4));
    if (got_nr.size() == 4) begin
      chk("t2_nr_0", 64'(got_nr[0]), -64'sd3);
      chk("t2_nr_1", 64'(got_nr[1]), -64'sd3);
      chk("t2_nr_2", 64'(got_nr[2]), -64'sd3);
      chk("t2_nr_3", 64'(got_nr[3]), -64'sd1);
    end
    push_exp(0, 0); push_exp(0, 0); push_exp(0, 0); push_exp(0, 1);
    check_out("t2");

    // 5x5 ramp followed back-to-back by a 4x4 ramp
    ramp(25);
    send_frame(5, 5);
    ramp(16);
    send_frame(4, 4);
    idle(5);
    push_exp(6, 0); push_exp(8, 0); push_exp(16, 0); push_exp(18, 1);
    push_exp(5, 0); push_exp(7, 0); push_exp(13, 0); push_exp(15, 1);
    check_out("t3");

    // Downstream stall of 5 cycles on the first pooled pixel
    ramp(16);
    fork
      send_frame(4, 4);
      begin
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(posedge clk); #1;
          seen = OUTPUT_TVALID;
        end
        chk("t4_first_valid", 64'(seen), 64'(1));
        OUTPUT_TREADY = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t4_hold_data",  64'($signed(OUTPUT_TDATA)), 64'(5));
          chk("t4_hold_valid", 64'(OUTPUT_TVALID), 64'(1));
          chk("t4_in_ready",   64'(INPUT_TREADY), '0);
        end
        @(posedge clk); #1;
        OUTPUT_TREADY = 1'b1;
      end
    join
    idle(5);
    push_exp(5, 0); push_exp(7, 0); push_exp(13, 0); push_exp(15, 1);
    check_out("t4");

    // Reset after 9 beats, then a fresh frame
    ramp(9);
    send_frame(4, 4);
    INPUT_TVALID = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_rst_tvalid", 64'(OUTPUT_TVALID), '0);
    chk("t5_rst_tdata",  64'($signed(OUTPUT_TDATA)), '0);
    chk("t5_rst_tlast",  64'(OUTPUT_TLAST), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    got_d.delete(); got_l.delete(); got_nr.delete();
    @(posedge clk); #1;
    ramp(16);
    send_frame(4, 4);
    idle(5);
    push_exp(5, 0); push_exp(7, 0); push_exp(13, 0); push_exp(15, 1);
    check_out("t5");

    // 1x8 degenerate frame, then a 2x2 frame
    for (int i = 0; i < 8; i++) stim.push_back(W'(100 + i));
    send_frame(1, 8);
    stim.push_back(W'(1)); stim.push_back(W'(9)); stim.push_back(W'(-4)); stim.push_back(W'(2));
    send_frame(2, 2);
    idle(5);
    push_exp(9, 1);
    check_out("t6");

    chk("relu_bypass_timing_match", 64'(diverge), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
